dp_mem_responder: RTL and testbench
===================================

# dp_mem_responder

Responder end of the datapath memory interface. Accepts the datapath's instruction-fetch and data load/store requests, arbitrates them onto a single-ported RAM with a variable-latency ready handshake, and returns one-cycle `ihit`/`dhit` pulses with load data. It sits between the single-cycle datapath and main memory. It also keeps per-port access counters and flags misaligned accesses.

## Interface
- Parameters:
- `BAD_WORD`, default 32'hBAD1BAD1. Load data returned for a misaligned access.
- Ports:
- `CLK` in 1: sole clock; all logic on rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `imemREN` in 1: instruction read request; level, held until `ihit`.
- `imemaddr` in 32: instruction byte address.
- `dmemREN` in 1: data read request; level, held until `dhit`.
- `dmemWEN` in 1: data write request; level, held until `dhit`. Never asserted together with `dmemREN`.
- `dmemaddr` in 32: data byte address.
- `dmemstore` in 32: store data.
- `halt` in 1: datapath halted.
- `ihit` out 1: one-cycle pulse completing an instruction read.
- `imemload` out 32: instruction word, valid while `ihit`=1.
- `dhit` out 1: one-cycle pulse completing a data read or write.
- `dmemload` out 32: load word, valid while `dhit`=1.
- `ram_req` out 1: RAM access strobe, held until `ram_ready`.
- `ram_wen` out 1: 1 = write, 0 = read; valid with `ram_req`.
- `ram_addr` out 32: word-aligned RAM byte address.
- `ram_wdata` out 32: write data.
- `ram_rdata` in 32: read data, valid with `ram_ready`.
- `ram_ready` in 1: RAM completes the current access this cycle.
- `misalign_err` out 1: sticky; set on any misaligned request.
- `icount` out 32: completed instruction reads, wraps at 2^32.
- `dcount` out 32: completed data accesses, wraps at 2^32.

## Operation
- FSM states: IDLE, DACC, IACC, RESP, HALTED.
- IDLE:
  - If `halt`=1: go to HALTED. `halt` has priority over pending requests.
  - Else if `dmemREN`|`dmemWEN`: latch request type, address and store data; go to DACC.
  - Else if `imemREN`: latch address; go to IACC.
  - Data has priority over instruction when both are pending.
- Misaligned access: latched address[1:0]≠0.
  - FSM goes straight to RESP; the RAM is not accessed.
  - Load data = `BAD_WORD`; a write is discarded.
  - `misalign_err` is set and stays set until reset.
- DACC/IACC:
  - `ram_req`=1; `ram_addr`, `ram_wen`, `ram_wdata` come from the latched request and stay stable.
  - On `ram_ready`=1: capture `ram_rdata` into the load register; go to RESP.
- RESP:
  - Pulse `ihit` or `dhit` according to the latched port.
  - Drive the load register onto `imemload`/`dmemload`; increment the matching counter.
  - Next state is HALTED if `halt`=1, else IDLE.
  - The one-cycle RESP hole guarantees a request dropped on the hit is never re-served.
- HALTED: no outputs asserted, all requests ignored, counters frozen. Exit only via `RST`.
- `halt` rising during DACC/IACC: the access completes and hits normally, then the FSM enters HALTED.
- `imemload`/`dmemload` are 0 whenever the matching hit is 0.

## Timing
- Reset values: state IDLE; `ihit`, `dhit`, `ram_req`, `ram_wen`, `misalign_err` = 0; `imemload`, `dmemload`, `ram_addr`, `ram_wdata`, `icount`, `dcount` = 0.
- `RST` mid-access: `ram_req` is 0 in the cycle after the reset edge; the in-flight access is abandoned with no hit.
- Request seen in IDLE at cycle N: `ram_req` high from N+1. If `ram_ready` first arrives at cycle M≥N+1, the hit is at M+1 and the FSM is back in IDLE at M+2.
- Minimum latency, request to hit: 2 cycles (`ram_ready` at N+1).
- Misaligned request: hit at N+1.
- `ram_ready` outside DACC/IACC is ignored.
- Counters wrap from 0xFFFFFFFF to 0 with no flag.

## Test plan
- Reset, then `imemREN`=1, `imemaddr`=0x40, RAM returns 0x8C220004 with zero extra wait (`ram_ready` at N+1): `ihit` at N+2 with `imemload`=0x8C220004, `icount`=1.
- Fetch and load both pending, `dmemaddr`=0x100, RAM latency 3 cycles per access: DACC served first and `dhit` precedes `ihit`, exactly one RAM strobe per access.
- Store 0xDEADBEEF to 0x104: `ram_wen`=1, `ram_wdata`=0xDEADBEEF, `ram_addr`=0x104; `dhit` one cycle after `ram_ready`; `dcount` increments.
- Load from 0x102: no `ram_req`; `dhit` at N+1 with `dmemload`=0xBAD1BAD1; `misalign_err`=1 and stays 1 until `RST`.
- `halt` raised during a 4-cycle read: that read completes with its hit, then HALTED; a further `imemREN` gets no `ihit` and no `ram_req`.
- `RST` asserted mid-access, and counter preloaded near 0xFFFFFFFF: all outputs return to reset values; the counter wraps to 0 after the next hit.

Source files
------------

// File: rtl/dp_mem_responder.sv
// Responder side of the datapath memory interface: arbitrates instruction fetch and
// data load/store requests onto one single-ported, ready-handshaked RAM and returns hit pulses.
module dp_mem_responder #(
  parameter logic [31:0] BAD_WORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        ram_req,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready,
  output logic        misalign_err,
  output logic [31:0] icount,
  output logic [31:0] dcount
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DACC   = 3'd1,
    IACC   = 3'd2,
    RESP   = 3'd3,
    HALTED = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        ihit_q, ihit_d;
  logic        dhit_q, dhit_d;
  logic [31:0] imemload_q, imemload_d;
  logic [31:0] dmemload_q, dmemload_d;
  logic        ram_req_q, ram_req_d;
  logic        ram_wen_q, ram_wen_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic        misalign_q, misalign_d;
  logic [31:0] icount_q, icount_d;
  logic [31:0] dcount_q, dcount_d;

  // Next-state and next-output logic; hits, load data and counters are set on entry to RESP.
  always_comb begin
    state_d     = state_q;
    ihit_d      = 1'b0;
    dhit_d      = 1'b0;
    imemload_d  = 32'd0;
    dmemload_d  = 32'd0;
    ram_req_d   = ram_req_q;
    ram_wen_d   = ram_wen_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    misalign_d  = misalign_q;
    icount_d    = icount_q;
    dcount_d    = dcount_q;
    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = HALTED;
        end else if (dmemREN || dmemWEN) begin
          if (dmemaddr[1:0] != 2'b00) begin
            // Misaligned: answer directly without touching the RAM.
            state_d    = RESP;
            dhit_d     = 1'b1;
            dmemload_d = BAD_WORD;
            dcount_d   = dcount_q + 32'd1;
            misalign_d = 1'b1;
          end else begin
            state_d     = DACC;
            ram_req_d   = 1'b1;
            ram_wen_d   = dmemWEN;
            ram_addr_d  = {dmemaddr[31:2], 2'b00};
            ram_wdata_d = dmemstore;
          end
        end else if (imemREN) begin
          if (imemaddr[1:0] != 2'b00) begin
            state_d    = RESP;
            ihit_d     = 1'b1;
            imemload_d = BAD_WORD;
            icount_d   = icount_q + 32'd1;
            misalign_d = 1'b1;
          end else begin
            state_d    = IACC;
            ram_req_d  = 1'b1;
            ram_wen_d  = 1'b0;
            ram_addr_d = {imemaddr[31:2], 2'b00};
          end
        end else begin
          state_d = IDLE;
        end
      end
      DACC: begin
        if (ram_ready) begin
          state_d    = RESP;
          ram_req_d  = 1'b0;
          ram_wen_d  = 1'b0;
          dhit_d     = 1'b1;
          dmemload_d = ram_rdata;
          dcount_d   = dcount_q + 32'd1;
        end else begin
          state_d = DACC;
        end
      end
      IACC: begin
        if (ram_ready) begin
          state_d    = RESP;
          ram_req_d  = 1'b0;
          ram_wen_d  = 1'b0;
          ihit_d     = 1'b1;
          imemload_d = ram_rdata;
          icount_d   = icount_q + 32'd1;
        end else begin
          state_d = IACC;
        end
      end
      RESP: begin
        // One idle cycle so a request dropped on the hit is not re-served.
        if (halt) begin
          state_d = HALTED;
        end else begin
          state_d = IDLE;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d   = IDLE;
        ram_req_d = 1'b0;
        ram_wen_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      ihit_q      <= 1'b0;
      dhit_q      <= 1'b0;
      imemload_q  <= 32'd0;
      dmemload_q  <= 32'd0;
      ram_req_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= 32'd0;
      ram_wdata_q <= 32'd0;
      misalign_q  <= 1'b0;
      icount_q    <= 32'd0;
      dcount_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      ihit_q      <= ihit_d;
      dhit_q      <= dhit_d;
      imemload_q  <= imemload_d;
      dmemload_q  <= dmemload_d;
      ram_req_q   <= ram_req_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      misalign_q  <= misalign_d;
      icount_q    <= icount_d;
      dcount_q    <= dcount_d;
    end
  end

  assign ihit         = ihit_q;
  assign dhit         = dhit_q;
  assign imemload     = imemload_q;
  assign dmemload     = dmemload_q;
  assign ram_req      = ram_req_q;
  assign ram_wen      = ram_wen_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign misalign_err = misalign_q;
  assign icount       = icount_q;
  assign dcount       = dcount_q;

endmodule

// File: tb/tb_dp_mem_responder.sv
// Directed bench for dp_mem_responder: a vector table of single accesses plus
// hand-written sequences for arbitration, halt, mid-access reset and counter wrap.
module tb_dp_mem_responder;

  logic        clk = 1'b0;
  logic        RST, imemREN, dmemREN, dmemWEN, halt, ram_ready;
  logic [31:0] imemaddr, dmemaddr, dmemstore, ram_rdata;
  logic        ihit, dhit, ram_req, ram_wen, misalign_err;
  logic [31:0] imemload, dmemload, ram_addr, ram_wdata, icount, dcount;

  int          total = 0;
  int          bad = 0;
  int          req_rises = 0;
  logic        req_prev = 1'b0;
  logic [31:0] exp_ic, exp_dc;

  typedef struct {
    logic [1:0]  kind;      // 0 fetch, 1 load, 2 store
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;       // extra cycles of ram_req before ram_ready
    logic [31:0] exp_load;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  dp_mem_responder #(.BAD_WORD(32'hBAD1BAD1)) dut (
    .CLK(clk), .RST(RST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .halt(halt),
    .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload),
    .ram_req(ram_req), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .misalign_err(misalign_err), .icount(icount), .dcount(dcount)
  );

  // Counts RAM strobes so each access can be shown to use exactly one.
  always @(posedge clk) begin
    if (ram_req && !req_prev) req_rises = req_rises + 1;
    req_prev = ram_req;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0; ram_ready = 1'b0;
    imemaddr = 32'd0; dmemaddr = 32'd0; dmemstore = 32'd0; ram_rdata = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    RST = 1'b1;
    idle_inputs();
    @(negedge clk);
    RST = 1'b0;
    exp_ic = 32'd0;
    exp_dc = 32'd0;
  endtask

  task automatic check_reset_state(input string tag);
    chk1({tag, "_ihit"}, ihit, 1'b0);
    chk1({tag, "_dhit"}, dhit, 1'b0);
    chk1({tag, "_req"}, ram_req, 1'b0);
    chk1({tag, "_wen"}, ram_wen, 1'b0);
    chk1({tag, "_mis"}, misalign_err, 1'b0);
    chk({tag, "_iload"}, imemload, 32'd0);
    chk({tag, "_dload"}, dmemload, 32'd0);
    chk({tag, "_addr"}, ram_addr, 32'd0);
    chk({tag, "_wdata"}, ram_wdata, 32'd0);
    chk({tag, "_icount"}, icount, 32'd0);
    chk({tag, "_dcount"}, dcount, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    logic aligned;
    aligned = (v.addr[1:0] == 2'b00);
    @(negedge clk);
    imemREN = (v.kind == 2'd0); dmemREN = (v.kind == 2'd1); dmemWEN = (v.kind == 2'd2);
    imemaddr = v.addr; dmemaddr = v.addr; dmemstore = v.wdata;
    @(negedge clk);
    if (aligned) begin
      chk1("vec_req", ram_req, 1'b1);
      chk("vec_addr", ram_addr, {v.addr[31:2], 2'b00});
      chk1("vec_wen", ram_wen, v.kind == 2'd2);
      if (v.kind == 2'd2) chk("vec_wdata", ram_wdata, v.wdata);
      for (int i = 0; i < v.lat; i++) begin
        @(negedge clk);
        chk1("vec_req_hold", ram_req, 1'b1);
        chk1("vec_early_hit", ihit | dhit, 1'b0);
      end
      ram_ready = 1'b1; ram_rdata = v.rdata;
      @(negedge clk);
      ram_ready = 1'b0; ram_rdata = 32'd0;
    end else begin
      chk1("vec_noreq", ram_req, 1'b0);
    end
    if (v.kind == 2'd0) exp_ic = exp_ic + 32'd1;
    else exp_dc = exp_dc + 32'd1;
    chk1("vec_ihit", ihit, v.kind == 2'd0);
    chk1("vec_dhit", dhit, v.kind != 2'd0);
    if (v.kind == 2'd0) chk("vec_imemload", imemload, v.exp_load);
    if (v.kind == 2'd1) chk("vec_dmemload", dmemload, v.exp_load);
    chk("vec_icount", icount, exp_ic);
    chk("vec_dcount", dcount, exp_dc);
    chk1("vec_misalign", misalign_err, v.exp_mis);
    chk1("vec_req_done", ram_req, 1'b0);
    imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    @(negedge clk);
    chk1("vec_hit_clear", ihit | dhit, 1'b0);
    chk("vec_iload_zero", imemload, 32'd0);
    chk("vec_dload_zero", dmemload, 32'd0);
  endtask

  initial begin
    int rises_before;
    RST = 1'b1;
    idle_inputs();
    exp_ic = 32'd0;
    exp_dc = 32'd0;

    vecs[0] = '{2'd0, 32'h0000_0040, 32'h0, 32'h8C22_0004, 0, 32'h8C22_0004, 1'b0};
    vecs[1] = '{2'd2, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 2, 32'h0, 1'b0};
    vecs[2] = '{2'd1, 32'h0000_0100, 32'h0, 32'h1234_5678, 3, 32'h1234_5678, 1'b0};
    vecs[3] = '{2'd0, 32'h0000_0044, 32'h0, 32'h0000_0020, 1, 32'h0000_0020, 1'b0};
    vecs[4] = '{2'd1, 32'h0000_0102, 32'h0, 32'h5555_5555, 0, 32'hBAD1_BAD1, 1'b1};
    vecs[5] = '{2'd0, 32'h0000_0048, 32'h0, 32'hAABB_CCDD, 0, 32'hAABB_CCDD, 1'b1};
    vecs[6] = '{2'd2, 32'h0000_0107, 32'h1111_2222, 32'h0, 0, 32'h0, 1'b1};
    vecs[7] = '{2'd0, 32'h0000_0041, 32'h0, 32'h7777_7777, 0, 32'hBAD1_BAD1, 1'b1};
    vecs[8] = '{2'd1, 32'hFFFF_FFFC, 32'h0, 32'h0F0F_0F0F, 4, 32'h0F0F_0F0F, 1'b1};

    do_reset();
    check_reset_state("rst0");

    for (int k = 0; k < 9; k++) run_vec(vecs[k]);
    chk1("mis_sticky", misalign_err, 1'b1);

    do_reset();
    check_reset_state("rst1");

    // Both ports pending: data first, then instruction, one strobe each.
    rises_before = req_rises;
    @(negedge clk);
    imemREN = 1'b1; imemaddr = 32'h0000_0200;
    dmemREN = 1'b1; dmemaddr = 32'h0000_0100;
    @(negedge clk);
    chk1("pri_req", ram_req, 1'b1);
    chk("pri_daddr", ram_addr, 32'h0000_0100);
    repeat (2) @(negedge clk);
    ram_ready = 1'b1; ram_rdata = 32'h1111_1111;
    @(negedge clk);
    ram_ready = 1'b0;
    chk1("pri_dhit", dhit, 1'b1);
    chk1("pri_no_ihit", ihit, 1'b0);
    chk("pri_dload", dmemload, 32'h1111_1111);
    dmemREN = 1'b0;
    @(negedge clk);
    chk1("pri_hole", ram_req, 1'b0);
    @(negedge clk);
    chk1("pri_ireq", ram_req, 1'b1);
    chk("pri_iaddr", ram_addr, 32'h0000_0200);
    repeat (2) @(negedge clk);
    ram_ready = 1'b1; ram_rdata = 32'h2222_2222;
    @(negedge clk);
    ram_ready = 1'b0;
    chk1("pri_ihit", ihit, 1'b1);
    chk("pri_iload", imemload, 32'h2222_2222);
    imemREN = 1'b0;
    @(negedge clk);
    chk("pri_strobes", req_rises - rises_before, 32'd2);
    chk("pri_icount", icount, 32'd1);
    chk("pri_dcount", dcount, 32'd1);

    // Halt raised during a 4-cycle read: read completes, then nothing is served.
    exp_ic = 32'd1;
    @(negedge clk);
    imemREN = 1'b1; imemaddr = 32'h0000_0060;
    @(negedge clk);
    chk1("halt_req", ram_req, 1'b1);
    halt = 1'b1;
    repeat (3) @(negedge clk);
    ram_ready = 1'b1; ram_rdata = 32'h600D_F00D;
    @(negedge clk);
    ram_ready = 1'b0;
    exp_ic = exp_ic + 32'd1;
    chk1("halt_ihit", ihit, 1'b1);
    chk("halt_iload", imemload, 32'h600D_F00D);
    @(negedge clk);
    halt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("halted_ihit", ihit, 1'b0);
      chk1("halted_req", ram_req, 1'b0);
    end
    chk("halted_icount", icount, exp_ic);

    do_reset();
    check_reset_state("rst2");

    // Reset in the middle of an access abandons it.
    @(negedge clk);
    imemREN = 1'b1; imemaddr = 32'h0000_0080;
    @(negedge clk);
    chk1("mid_req", ram_req, 1'b1);
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0; imemREN = 1'b0;
    check_reset_state("mid_rst");
    ram_ready = 1'b1; ram_rdata = 32'h9999_9999;
    @(negedge clk);
    ram_ready = 1'b0;
    chk1("stray_ready_ihit", ihit, 1'b0);
    chk1("stray_ready_req", ram_req, 1'b0);
    @(negedge clk);
    chk("stray_icount", icount, 32'd0);

    // Preload the fetch counter just below wrap.
    @(negedge clk);
    force dut.icount_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.icount_q;
    @(negedge clk);
    chk("wrap_preload", icount, 32'hFFFF_FFFF);
    exp_ic = 32'hFFFF_FFFF;
    exp_dc = 32'd0;
    run_vec('{2'd0, 32'h0000_0010, 32'h0, 32'h0000_ABCD, 1, 32'h0000_ABCD, 1'b0});
    chk("wrap_zero", icount, 32'd0);
    run_vec('{2'd0, 32'h0000_0014, 32'h0, 32'h0000_1234, 0, 32'h0000_1234, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
